// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared states, packet encodings, PID/SYNC bytes and CRC16 helpers for the USB TX sequencer.
package usb_tx_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_SYNC, S_PID, S_PAYLOAD, S_CRC_LO, S_CRC_HI, S_DRAIN, S_EOP, S_EOP_J
    } state_t;

    typedef enum logic [1:0] {
        PKT_NONE  = 2'b00,
        PKT_DATA0 = 2'b01,
        PKT_ACK   = 2'b10,
        PKT_NAK   = 2'b11
    } pkt_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;

    // USB polynomial 0x8005 in bit-reversed form, since bytes are processed LSB first
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++)
            c = (c >> 1) ^ ((c[0] ^ data[i]) ? CRC16_POLY_REFL : 16'h0000);
        return c;
    endfunction

    function automatic logic [7:0] pid_byte(input pkt_t kind);
        return kind == PKT_DATA0 ? PID_DATA0 : kind == PKT_ACK ? PID_ACK : PID_NAK;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// usb_crc16: byte-wise USB CRC16 register with synchronous clear and per-byte update.
module usb_crc16
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        update,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_next;

    assign crc_next = crc16_byte(crc, data);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            crc <= CRC16_INIT;
        else if (clear)
            crc <= CRC16_INIT;
        else if (update)
            crc <= crc_next;
    end

endmodule

// File: rtl/tx_packet_sequencer.sv
// tx_packet_sequencer: feeds SYNC, PID, payload, CRC16 and EOP bytes to the USB TX shifter.
// Define TX_WATCHDOG_EN to abort a stalled packet with tx_error and a forced EOP.
module tx_packet_sequencer
    import usb_tx_pkg::*;
#(
    parameter int unsigned BIT_CYCLES  = 8,
    parameter int unsigned MAX_PAYLOAD = 64
`ifdef TX_WATCHDOG_EN
    ,
    parameter int unsigned WDOG_CYCLES = 256
`endif
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [1:0] tx_packet,
    input  logic [7:0] tx_packet_data,
    input  logic [6:0] buffer_occupancy,
    input  logic       shifter_ready,
    output logic [7:0] tx_data,
    output logic       load_enable,
    output logic       get_tx_packet_data,
    output logic       eop,
    output logic       tx_transfer_active,
    output logic       tx_error
);

    localparam int TW = $clog2(2 * BIT_CYCLES);

    state_t        state;
    pkt_t          kind;
    logic [6:0]    byte_cnt;
    logic [TW-1:0] tcnt;
    logic          ready_q;
    logic          take;
    logic          wdog_hit;
    logic [15:0]   crc;

    // one load per shifter_ready pulse: act only on its first cycle
    assign take = shifter_ready && !ready_q;

    usb_crc16 crc16 (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (state == S_IDLE && tx_packet != PKT_NONE),
        .update (state == S_PAYLOAD && take && buffer_occupancy != 7'd0),
        .data   (tx_packet_data),
        .crc    (crc)
    );

`ifdef TX_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES) + 1;
    logic [WW-1:0] wdog;
    logic          waiting;
    assign waiting  = state inside {S_SYNC, S_PID, S_PAYLOAD, S_CRC_LO, S_CRC_HI, S_DRAIN};
    assign wdog_hit = waiting && !shifter_ready && wdog == WW'(WDOG_CYCLES - 1);
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            wdog <= '0;
        else
            wdog <= (waiting && !shifter_ready && !wdog_hit) ? wdog + 1'b1 : '0;
    end
`else
    assign wdog_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state              <= S_IDLE;
            kind               <= PKT_NONE;
            byte_cnt           <= '0;
            tcnt               <= '0;
            ready_q            <= 1'b0;
            tx_data            <= '0;
            load_enable        <= 1'b0;
            get_tx_packet_data <= 1'b0;
            eop                <= 1'b0;
            tx_transfer_active <= 1'b0;
            tx_error           <= 1'b0;
        end else begin
            ready_q            <= shifter_ready;
            load_enable        <= 1'b0;
            get_tx_packet_data <= 1'b0;
            if (wdog_hit) begin
                tx_error <= 1'b1;
                eop      <= 1'b1;
                tcnt     <= '0;
                state    <= S_EOP;
            end else begin
                case (state)
                    S_IDLE: if (tx_packet != PKT_NONE) begin
                        kind               <= pkt_t'(tx_packet);
                        byte_cnt           <= buffer_occupancy;
                        tx_transfer_active <= 1'b1;
                        tx_error           <= 1'b0;
                        state              <= S_SYNC;
                    end
                    S_SYNC: if (kind == PKT_DATA0 && byte_cnt > 7'(MAX_PAYLOAD)) begin
                        tx_error           <= 1'b1;
                        tx_transfer_active <= 1'b0;
                        state              <= S_IDLE;
                    end else if (take) begin
                        load_enable <= 1'b1;
                        tx_data     <= SYNC_BYTE;
                        state       <= S_PID;
                    end
                    S_PID: if (take) begin
                        load_enable <= 1'b1;
                        tx_data     <= pid_byte(kind);
                        state       <= kind != PKT_DATA0 ? S_DRAIN : byte_cnt == 7'd0 ? S_CRC_LO : S_PAYLOAD;
                    end
                    S_PAYLOAD: if (buffer_occupancy == 7'd0) begin
                        tx_error <= 1'b1;
                        state    <= S_DRAIN;
                    end else if (take) begin
                        load_enable        <= 1'b1;
                        get_tx_packet_data <= 1'b1;
                        tx_data            <= tx_packet_data;
                        byte_cnt           <= byte_cnt - 7'd1;
                        state              <= byte_cnt == 7'd1 ? S_CRC_LO : S_PAYLOAD;
                    end
                    S_CRC_LO: if (take) begin
                        load_enable <= 1'b1;
                        tx_data     <= ~crc[7:0];
                        state       <= S_CRC_HI;
                    end
                    S_CRC_HI: if (take) begin
                        load_enable <= 1'b1;
                        tx_data     <= ~crc[15:8];
                        state       <= S_DRAIN;
                    end
                    S_DRAIN: if (take) begin
                        eop   <= 1'b1;
                        tcnt  <= '0;
                        state <= S_EOP;
                    end
                    S_EOP: if (tcnt == TW'(2 * BIT_CYCLES - 1)) begin
                        eop   <= 1'b0;
                        tcnt  <= '0;
                        state <= S_EOP_J;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                    S_EOP_J: if (tcnt == TW'(BIT_CYCLES - 1)) begin
                        tcnt               <= '0;
                        tx_transfer_active <= 1'b0;
                        state              <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_packet_sequencer.sv
// tb_tx_packet_sequencer: randomized self-checking bench with a FIFO/shifter model and a CRC16 reference.
// Define TX_WATCHDOG_EN to also exercise the stall watchdog.
module tb_tx_packet_sequencer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [1:0] tx_packet;
    logic [7:0] tx_packet_data;
    logic [6:0] buffer_occupancy;
    logic       shifter_ready;
    logic [7:0] tx_data;
    logic       load_enable;
    logic       get_tx_packet_data;
    logic       eop;
    logic       tx_transfer_active;
    logic       tx_error;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] fifo[$];
    logic [7:0] pay[$];
    logic [8:0] loads[$];
    logic [8:0] exp_b[$];
    int  stray_get, eop_len, j_len, act_len, pops;
    int  rdy_cnt, ready_period, underrun_after;
    bit  force_empty;
    bit  to;

    always #5 clk = ~clk;

    tx_packet_sequencer dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .tx_packet          (tx_packet),
        .tx_packet_data     (tx_packet_data),
        .buffer_occupancy   (buffer_occupancy),
        .shifter_ready      (shifter_ready),
        .tx_data            (tx_data),
        .load_enable        (load_enable),
        .get_tx_packet_data (get_tx_packet_data),
        .eop                (eop),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error)
    );

    // Reference CRC: MSB-first register over the LSB-first bit stream, then reflected and inverted.
    function automatic logic [15:0] crc_tx(input logic [7:0] d[$]);
        logic [15:0] c, r;
        bit fb;
        c = 16'hFFFF;
        foreach (d[k])
            for (int i = 0; i < 8; i++) begin
                fb = c[15] ^ d[k][i];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
        for (int i = 0; i < 16; i++) r[i] = c[15 - i];
        return ~r;
    endfunction

    // Expected byte stream as {pop_flag, byte}
    function automatic void model(input logic [1:0] t, input logic [7:0] p[$]);
        logic [15:0] c;
        exp_b.delete();
        exp_b.push_back({1'b0, 8'h80});
        exp_b.push_back({1'b0, t == 2'd1 ? 8'hC3 : t == 2'd2 ? 8'hD2 : 8'h5A});
        if (t == 2'd1) begin
            foreach (p[i]) exp_b.push_back({1'b1, p[i]});
            c = crc_tx(p);
            exp_b.push_back({1'b0, c[7:0]});
            exp_b.push_back({1'b0, c[15:8]});
        end
    endfunction

    function automatic string hexs(input logic [8:0] q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%03h ", q[i])};
        return s;
    endfunction

    task automatic drive_fifo();
        buffer_occupancy = force_empty ? 7'd0 : 7'(fifo.size());
        tx_packet_data   = fifo.size() != 0 ? fifo[0] : 8'h00;
    endtask

    task automatic tick();
        @(negedge clk);
        if (get_tx_packet_data) begin
            if (fifo.size() != 0) void'(fifo.pop_front());
            pops++;
            if (pops == underrun_after) force_empty = 1'b1;
        end
        if (load_enable) loads.push_back({get_tx_packet_data, tx_data});
        else if (get_tx_packet_data) stray_get++;
        if (eop) eop_len++;
        else if (tx_transfer_active && eop_len > 0) j_len++;
        if (tx_transfer_active) act_len++;
        rdy_cnt++;
        shifter_ready = ready_period != 0 && rdy_cnt % ready_period == 0;
        drive_fifo();
    endtask

    task automatic fill(input int n);
        fifo.delete();
        for (int i = 0; i < n; i++) fifo.push_back(8'($urandom));
        pay = fifo;
    endtask

    task automatic send(input logic [1:0] t, output bit timeout);
        loads.delete();
        stray_get = 0; eop_len = 0; j_len = 0; act_len = 0; pops = 0;
        drive_fifo();
        tx_packet = t;
        timeout = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tx_transfer_active) begin timeout = 1'b0; break; end
        end
        tx_packet = 2'b00;
        if (!timeout) begin
            timeout = 1'b1;
            for (int i = 0; i < 20000; i++) begin
                tick();
                if (!tx_transfer_active) begin timeout = 1'b0; break; end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        compared++;
        if ({tx_data, load_enable, get_tx_packet_data, eop, tx_transfer_active, tx_error} !== 13'h0) begin
            mismatched++;
            $display("FAIL reset_held outputs=%h want 0", {tx_data, load_enable, get_tx_packet_data, eop, tx_transfer_active, tx_error});
        end
        n_rst = 1'b1;
        repeat (3) tick();
        compared++;
        if ({tx_data, load_enable, get_tx_packet_data, eop, tx_transfer_active, tx_error} !== 13'h0) begin
            mismatched++;
            $display("FAIL reset_idle outputs=%h want 0", {tx_data, load_enable, get_tx_packet_data, eop, tx_transfer_active, tx_error});
        end
    endtask

    task automatic test_ack();
        ready_period = 64;
        fill(0);
        model(2'd2, pay);
        send(2'd2, to);
        compared++; if (to) begin mismatched++; $display("FAIL ack_timeout timed out"); end
        compared++; if (hexs(loads) != hexs(exp_b)) begin mismatched++; $display("FAIL ack_seq got=%s want=%s", hexs(loads), hexs(exp_b)); end
        compared++; if (eop_len != 16) begin mismatched++; $display("FAIL ack_eop_len got=%0d want=16", eop_len); end
        compared++; if (j_len != 8) begin mismatched++; $display("FAIL ack_j_len got=%0d want=8", j_len); end
        compared++; if (tx_error !== 1'b0) begin mismatched++; $display("FAIL ack_error got=%b want=0", tx_error); end
    endtask

    task automatic test_zero_length();
        ready_period = 12;
        fill(0);
        model(2'd1, pay);
        send(2'd1, to);
        compared++; if (to) begin mismatched++; $display("FAIL zlp_timeout timed out"); end
        compared++; if (hexs(loads) != hexs(exp_b)) begin mismatched++; $display("FAIL zlp_seq got=%s want=%s", hexs(loads), hexs(exp_b)); end
        compared++; if (stray_get != 0 || pops != 0) begin mismatched++; $display("FAIL zlp_pops got=%0d want=0", pops + stray_get); end
        compared++; if (eop_len != 16 || j_len != 8) begin mismatched++; $display("FAIL zlp_eop got=%0d/%0d want=16/8", eop_len, j_len); end
    endtask

    task automatic test_payload();
        ready_period = 20;
        fifo = '{8'h01, 8'h02, 8'h03};
        pay = fifo;
        model(2'd1, pay);
        send(2'd1, to);
        compared++; if (to) begin mismatched++; $display("FAIL pay_timeout timed out"); end
        compared++; if (hexs(loads) != hexs(exp_b)) begin mismatched++; $display("FAIL pay_seq got=%s want=%s", hexs(loads), hexs(exp_b)); end
        compared++; if (pops != 3 || stray_get != 0) begin mismatched++; $display("FAIL pay_pops got=%0d stray=%0d want=3/0", pops, stray_get); end
        compared++; if (eop_len != 16 || j_len != 8 || tx_error !== 1'b0) begin mismatched++; $display("FAIL pay_end got=%0d/%0d/%b want=16/8/0", eop_len, j_len, tx_error); end
    endtask

    task automatic test_oversize();
        ready_period = 6;
        fill(65);
        send(2'd1, to);
        fifo.delete();
        compared++; if (to) begin mismatched++; $display("FAIL big_timeout timed out"); end
        compared++; if (loads.size() != 0) begin mismatched++; $display("FAIL big_loads got=%0d want=0", loads.size()); end
        compared++; if (act_len != 1) begin mismatched++; $display("FAIL big_active got=%0d want=1", act_len); end
        compared++; if (tx_error !== 1'b1 || eop_len != 0) begin mismatched++; $display("FAIL big_error got=%b eop=%0d want=1/0", tx_error, eop_len); end
    endtask

    task automatic test_underrun();
        ready_period = 16;
        fill(4);
        underrun_after = 1;
        exp_b = '{9'h080, 9'h0C3, {1'b1, pay[0]}};
        send(2'd1, to);
        underrun_after = -1;
        force_empty = 1'b0;
        fifo.delete();
        compared++; if (to) begin mismatched++; $display("FAIL urun_timeout timed out"); end
        compared++; if (hexs(loads) != hexs(exp_b)) begin mismatched++; $display("FAIL urun_seq got=%s want=%s", hexs(loads), hexs(exp_b)); end
        compared++; if (tx_error !== 1'b1) begin mismatched++; $display("FAIL urun_error got=%b want=1", tx_error); end
        compared++; if (eop_len != 16 || j_len != 8) begin mismatched++; $display("FAIL urun_eop got=%0d/%0d want=16/8", eop_len, j_len); end
    endtask

    task automatic test_reset_mid();
        bit got = 1'b0;
        ready_period = 8;
        fill(10);
        loads.delete();
        drive_fifo();
        tx_packet = 2'd1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (tx_transfer_active) tx_packet = 2'b00;
            if (get_tx_packet_data) begin got = 1'b1; break; end
        end
        tx_packet = 2'b00;
        compared++; if (!got) begin mismatched++; $display("FAIL rmid_reach never reached payload"); end
        #2 n_rst = 1'b0;
        #1;
        compared++;
        if ({tx_data, load_enable, get_tx_packet_data, eop, tx_transfer_active, tx_error} !== 13'h0) begin
            mismatched++;
            $display("FAIL rmid_async outputs=%h want 0", {tx_data, load_enable, get_tx_packet_data, eop, tx_transfer_active, tx_error});
        end
        tick();
        n_rst = 1'b1;
        fifo.delete();
        eop_len = 0; act_len = 0;
        repeat (40) tick();
        compared++; if (eop_len != 0 || act_len != 0) begin mismatched++; $display("FAIL rmid_quiet eop=%0d active=%0d want 0/0", eop_len, act_len); end
    endtask

    task automatic test_random();
        logic [1:0] t;
        for (int n = 0; n < 8; n++) begin
            t = 2'($urandom_range(1, 3));
            ready_period = $urandom_range(4, 40);
            fill($urandom_range(0, 24));
            model(t, pay);
            repeat ($urandom_range(0, 5)) tick();
            send(t, to);
            fifo.delete();
            compared++; if (to) begin mismatched++; $display("FAIL rnd%0d_timeout timed out", n); end
            compared++; if (hexs(loads) != hexs(exp_b)) begin mismatched++; $display("FAIL rnd%0d_seq got=%s want=%s", n, hexs(loads), hexs(exp_b)); end
            compared++; if (eop_len != 16 || j_len != 8 || tx_error !== 1'b0 || stray_get != 0) begin
                mismatched++;
                $display("FAIL rnd%0d_end eop=%0d j=%0d err=%b stray=%0d want 16/8/0/0", n, eop_len, j_len, tx_error, stray_get);
            end
        end
    endtask

`ifdef TX_WATCHDOG_EN
    task automatic test_watchdog();
        ready_period = 0;
        fill(0);
        send(2'd2, to);
        compared++; if (to) begin mismatched++; $display("FAIL wdog_timeout timed out"); end
        compared++; if (tx_error !== 1'b1 || loads.size() != 0) begin mismatched++; $display("FAIL wdog_error err=%b loads=%0d want 1/0", tx_error, loads.size()); end
        compared++; if (eop_len != 16) begin mismatched++; $display("FAIL wdog_eop got=%0d want=16", eop_len); end
    endtask
`endif

    initial begin
        n_rst = 1'b0;
        tx_packet = 2'b00;
        shifter_ready = 1'b0;
        tx_packet_data = 8'h00;
        buffer_occupancy = 7'd0;
        ready_period = 64;
        underrun_after = -1;
        force_empty = 1'b0;
        rdy_cnt = 0;
        test_reset();
        test_ack();
        test_zero_length();
        test_payload();
        test_oversize();
        test_underrun();
        test_reset_mid();
        test_random();
`ifdef TX_WATCHDOG_EN
        test_watchdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
